// File: rtl/mesm6_defines.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : mesm6_defines                                           |
// | Purpose    : Shared widths, timeout limit and FSM state encoding for |
// |              the MESM6 core/memory bus arbiter.                      |
// | Contents   : C_ADDR_W, C_DATA_W, C_TIMEOUT_LIMIT, state_t            |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package mesm6_defines;

  localparam int C_ADDR_W = 15;
  localparam int C_DATA_W = 48;

  // Number of ACCESS cycles without mem_ack before the access is forced
  // to complete with a bus error.
  localparam logic [7:0] C_TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mesm6_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : mesm6_bus_arbiter                                       |
// | Purpose    : Merges the core instruction port (ibus) and data port   |
// |              (dbus) onto one memory port, one transaction at a time, |
// |              with alternating priority and an access timeout.        |
// | Ports      : clk, reset (async, active low)                          |
// |              ibus_fetch/ibus_addr -> ibus_input/ibus_done            |
// |              dbus_read/dbus_write/dbus_addr/dbus_output              |
// |                -> dbus_input/dbus_done                               |
// |              mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ack  |
// |              bus_error (sticky timeout flag), err_clear              |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module mesm6_bus_arbiter
  import mesm6_defines::*;
(
  input  logic                clk,
  input  logic                reset,
  // instruction port
  input  logic                ibus_fetch,
  input  logic [C_ADDR_W-1:0] ibus_addr,
  output logic [C_DATA_W-1:0] ibus_input,
  output logic                ibus_done,
  // data port
  input  logic                dbus_read,
  input  logic                dbus_write,
  input  logic [C_ADDR_W-1:0] dbus_addr,
  input  logic [C_DATA_W-1:0] dbus_output,
  output logic [C_DATA_W-1:0] dbus_input,
  output logic                dbus_done,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [C_ADDR_W-1:0] mem_addr,
  output logic [C_DATA_W-1:0] mem_wdata,
  input  logic [C_DATA_W-1:0] mem_rdata,
  input  logic                mem_ack,
  // error status
  output logic                bus_error,
  input  logic                err_clear
);

  state_t       r_state;
  state_t       w_state_next;
  logic         r_armed;       // set one edge after reset release
  logic         r_grant_dbus;  // port owning the current transaction
  logic         r_last_dbus;   // previous grant went to dbus
  logic         r_rd;          // current transaction returns data
  logic [7:0]   r_timeout;

  logic         w_ibus_pend;
  logic         w_dbus_pend;
  logic         w_grant;
  logic         w_pick_dbus;
  logic         w_complete;
  logic         w_timeout_hit;

  assign w_ibus_pend = ibus_fetch;
  assign w_dbus_pend = dbus_read | dbus_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant       = 1'b0;
    w_pick_dbus   = 1'b0;
    w_complete    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_armed holds off the first grant to the second edge after reset.
        if (r_armed && (w_ibus_pend || w_dbus_pend)) begin
          w_grant      = 1'b1;
          // dbus normally wins a tie; ibus wins if dbus had the last grant.
          w_pick_dbus  = w_dbus_pend && !(w_ibus_pend && r_last_dbus);
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          w_complete   = 1'b1;
          w_state_next = ST_RESP;
        end else if (r_timeout == (C_TIMEOUT_LIMIT - 8'd1)) begin
          // This cycle brings the counter to the limit: abandon the access.
          w_timeout_hit = 1'b1;
          w_state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        // Requests still high here are ignored; IDLE re-samples next cycle.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed      <= 1'b0;
      r_grant_dbus <= 1'b0;
      r_last_dbus  <= 1'b0;
      r_rd         <= 1'b0;
      r_timeout    <= 8'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ibus_done    <= 1'b0;
      dbus_done    <= 1'b0;
      ibus_input   <= '0;
      dbus_input   <= '0;
      bus_error    <= 1'b0;
    end else begin
      r_armed   <= 1'b1;
      ibus_done <= 1'b0;
      dbus_done <= 1'b0;

      if (w_grant) begin
        mem_req      <= 1'b1;
        r_grant_dbus <= w_pick_dbus;
        r_last_dbus  <= w_pick_dbus;
        r_timeout    <= 8'd0;
        if (w_pick_dbus) begin
          mem_we    <= dbus_write;
          mem_addr  <= dbus_addr;
          mem_wdata <= dbus_output;
          r_rd      <= dbus_read;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= ibus_addr;
          r_rd      <= 1'b1;
        end
      end

      if ((r_state == ST_ACCESS) && !mem_ack) begin
        r_timeout <= r_timeout + 8'd1;
      end

      if (w_complete || w_timeout_hit) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        // A timed-out read returns zero; a write never touches dbus_input.
        if (r_grant_dbus) begin
          dbus_done <= 1'b1;
          if (r_rd) begin
            dbus_input <= w_complete ? mem_rdata : '0;
          end
        end else begin
          ibus_done  <= 1'b1;
          ibus_input <= w_complete ? mem_rdata : '0;
        end
      end

      // A timeout in the same cycle as err_clear keeps the flag set.
      if (w_timeout_hit) begin
        bus_error <= 1'b1;
      end else if (err_clear) begin
        bus_error <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mesm6_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_mesm6_bus_arbiter                                    |
// | Purpose    : Directed self-checking bench for mesm6_bus_arbiter with |
// |              a memory responder of programmable wait states.         |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_mesm6_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read;
  logic        dbus_write;
  logic [14:0] dbus_addr;
  logic [47:0] dbus_output;
  logic [47:0] dbus_input;
  logic        dbus_done;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata;
  logic        mem_ack;
  logic        bus_error;
  logic        err_clear;

  mesm6_bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .ibus_fetch  (ibus_fetch),
    .ibus_addr   (ibus_addr),
    .ibus_input  (ibus_input),
    .ibus_done   (ibus_done),
    .dbus_read   (dbus_read),
    .dbus_write  (dbus_write),
    .dbus_addr   (dbus_addr),
    .dbus_output (dbus_output),
    .dbus_input  (dbus_input),
    .dbus_done   (dbus_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .bus_error   (bus_error),
    .err_clear   (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_wait cycles of mem_req.
  bit          ack_en    = 1'b1;
  int          ack_wait  = 0;
  logic [47:0] rdata_val = '0;
  int          wcnt      = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (mem_req && ack_en && (wcnt >= ack_wait)) begin
      mem_ack   = 1'b1;
      mem_rdata = rdata_val;
    end else begin
      mem_ack = 1'b0;
    end
    if (mem_req) wcnt = wcnt + 1;
    else         wcnt = 0;
  end

  // Event monitor: done pulses, request cycles, and granted addresses.
  int          n_idone = 0;
  int          n_ddone = 0;
  int          n_reqc  = 0;
  logic        prev_req = 1'b0;
  logic [14:0] gq[$];

  always @(negedge clk) begin
    if (ibus_done) n_idone = n_idone + 1;
    if (dbus_done) n_ddone = n_ddone + 1;
    if (mem_req) n_reqc = n_reqc + 1;
    if (mem_req && !prev_req) gq.push_back(mem_addr);
    prev_req = mem_req;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Tick until the selected done is seen or the budget expires.
  task automatic wait_done(input string tag, input bit on_dbus, input int budget, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cyc++;
      if (on_dbus ? dbus_done : ibus_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {63'd0, seen}, 64'd1);
  endtask

  int          cyc;
  int          b_i, b_d, b_r, b_g;
  int          bad_cyc;
  logic        wr_seen;
  logic        first_dbus;
  logic        got_i, got_d;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ibus_fetch = 1'b0; ibus_addr = '0;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_addr = '0; dbus_output = '0;
    err_clear = 1'b0;
    ack_en = 1'b1; ack_wait = 0; rdata_val = 48'h0123456789AB;

    // Reset state
    repeat (3) tick();
    check("rst_mem_req",   {63'd0, mem_req}, 64'd0);
    check("rst_mem_we",    {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr",  {49'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 64'd0);
    check("rst_dones",     {62'd0, ibus_done, dbus_done}, 64'd0);
    check("rst_inputs",    {16'd0, ibus_input | dbus_input}, 64'd0);
    check("rst_bus_error", {63'd0, bus_error}, 64'd0);

    // Fetch right at release: no grant on the first edge, zero-wait ack
    @(posedge clk); #1;
    reset = 1'b1; ibus_fetch = 1'b1; ibus_addr = 15'h0100;
    tick();
    tick();
    check("arm_delay_no_req", {63'd0, mem_req}, 64'd0);
    tick();
    check("fetch_req",  {63'd0, mem_req}, 64'd1);
    check("fetch_addr", {49'd0, mem_addr}, 64'h0100);
    check("fetch_we",   {63'd0, mem_we}, 64'd0);
    tick();
    check("fetch_done_n2", {63'd0, ibus_done}, 64'd1);
    check("fetch_data",    {16'd0, ibus_input}, 64'h0123456789AB);
    check("fetch_no_ddone", {63'd0, dbus_done}, 64'd0);
    ibus_fetch = 1'b0;
    tick();
    check("fetch_done_pulse", {63'd0, ibus_done}, 64'd0);
    check("fetch_data_hold",  {16'd0, ibus_input}, 64'h0123456789AB);
    tick();

    // Both ports together with last grant = ibus: dbus then ibus
    b_i = n_idone; b_d = n_ddone; b_g = gq.size();
    rdata_val = 48'h111;
    ibus_fetch = 1'b1; ibus_addr = 15'h0200;
    dbus_read  = 1'b1; dbus_addr = 15'h0300;
    first_dbus = 1'b0; got_i = 1'b0; got_d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dbus_done) begin
        if (!got_i) first_dbus = 1'b1;
        got_d = 1'b1; dbus_read = 1'b0; rdata_val = 48'h222;
      end
      if (ibus_done) begin
        got_i = 1'b1; ibus_fetch = 1'b0;
      end
      if (got_i && got_d) break;
    end
    repeat (4) tick();
    check("arb_dbus_first", {63'd0, first_dbus}, 64'd1);
    check("arb_grants", gq.size() - b_g, 64'd2);
    if (gq.size() - b_g == 2) begin
      check("arb_grant0_addr", {49'd0, gq[b_g]},   64'h0300);
      check("arb_grant1_addr", {49'd0, gq[b_g+1]}, 64'h0200);
    end
    check("arb_ddone_cnt", n_ddone - b_d, 64'd1);
    check("arb_idone_cnt", n_idone - b_i, 64'd1);
    check("arb_dbus_data", {16'd0, dbus_input}, 64'h111);
    check("arb_ibus_data", {16'd0, ibus_input}, 64'h222);

    // dbus_read held across two accesses: two distinct transactions
    b_d = n_ddone; b_g = gq.size();
    rdata_val = 48'hA;
    dbus_read = 1'b1; dbus_addr = 15'd5;
    wait_done("rd1_done", 1'b1, 20, cyc);
    check("rd1_data", {16'd0, dbus_input}, 64'hA);
    dbus_addr = 15'd6; rdata_val = 48'hB;
    wait_done("rd2_done", 1'b1, 20, cyc);
    check("rd_b2b_spacing", cyc, 64'd3);
    check("rd2_data", {16'd0, dbus_input}, 64'hB);
    dbus_read = 1'b0;
    repeat (4) tick();
    check("rd_grants", gq.size() - b_g, 64'd2);
    if (gq.size() - b_g == 2) begin
      check("rd_addr_seq", {34'd0, gq[b_g], gq[b_g+1]}, {34'd0, 15'd5, 15'd6});
    end
    check("rd_ddone_cnt", n_ddone - b_d, 64'd2);

    // Write with 5 wait states
    b_i = n_idone; b_d = n_ddone; b_r = n_reqc;
    ack_wait = 5;
    dbus_write = 1'b1; dbus_addr = 15'h7FFF; dbus_output = 48'hFFFFFFFFFFFF;
    bad_cyc = 0; wr_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem_req && (mem_we !== 1'b1 || mem_wdata !== 48'hFFFFFFFFFFFF || mem_addr !== 15'h7FFF))
        bad_cyc++;
      if (dbus_done) begin
        wr_seen = 1'b1;
        break;
      end
    end
    dbus_write = 1'b0;
    check("wr_done_seen", {63'd0, wr_seen}, 64'd1);
    check("wr_fields_stable", bad_cyc, 64'd0);
    check("wr_req_cycles", n_reqc - b_r, 64'd6);
    check("wr_dbus_input_kept", {16'd0, dbus_input}, 64'hB);
    repeat (3) tick();
    check("wr_ddone_cnt", n_ddone - b_d, 64'd1);
    check("wr_no_idone", n_idone - b_i, 64'd0);
    ack_wait = 0;

    // Timeout on a dbus read
    ack_en = 1'b0;
    b_r = n_reqc;
    dbus_read = 1'b1; dbus_addr = 15'h0010;
    wait_done("to_done", 1'b1, 300, cyc);
    check("to_req_cycles", n_reqc - b_r, 64'd255);
    check("to_mem_req_dropped", {63'd0, mem_req}, 64'd0);
    check("to_dbus_zero", {16'd0, dbus_input}, 64'd0);
    check("to_bus_error", {63'd0, bus_error}, 64'd1);
    dbus_read = 1'b0;
    repeat (3) tick();
    check("to_error_sticky", {63'd0, bus_error}, 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("to_error_cleared", {63'd0, bus_error}, 64'd0);

    // Timeout on ibus with err_clear held high: timeout wins
    err_clear = 1'b1;
    ibus_fetch = 1'b1; ibus_addr = 15'h0020;
    wait_done("to2_done", 1'b0, 300, cyc);
    err_clear = 1'b0;
    ibus_fetch = 1'b0;
    check("to2_error_wins", {63'd0, bus_error}, 64'd1);
    check("to2_ibus_zero", {16'd0, ibus_input}, 64'd0);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("to2_error_cleared", {63'd0, bus_error}, 64'd0);
    tick();

    // Reset during ACCESS
    ibus_fetch = 1'b1; ibus_addr = 15'h0040;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req) break;
    end
    check("rstmid_req_up", {63'd0, mem_req}, 64'd1);
    tick();
    #1;
    reset = 1'b0;
    #1;
    check("rstmid_req_async_drop", {63'd0, mem_req}, 64'd0);
    ibus_fetch = 1'b0;
    ack_en = 1'b1;
    rdata_val = 48'hCAFE;
    tick();
    tick();
    b_i = n_idone; b_d = n_ddone;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) tick();
    check("rstmid_no_done", (n_idone - b_i) + (n_ddone - b_d), 64'd0);
    ibus_fetch = 1'b1; ibus_addr = 15'h0041;
    wait_done("rstmid_fetch_done", 1'b0, 20, cyc);
    ibus_fetch = 1'b0;
    check("rstmid_fetch_data", {16'd0, ibus_input}, 64'hCAFE);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mesm6_bus_arbiter.md
MESM6_BUS_ARBITER -- requirements
Module: mesm6_bus_arbiter

Interface
REQ-001 clk  in  1  system clock, all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-003 ibus_fetch  in  1  core instruction fetch request, level, held until ibus_done.
REQ-004 ibus_addr  in  15  fetch word address.
REQ-005 ibus_input  out  48  fetched instruction word.
REQ-006 ibus_done  out  1  fetch complete, one-cycle pulse.
REQ-007 dbus_read / dbus_write  in  1 each  core data read/write request, level, held until dbus_done; never both set.
REQ-008 dbus_addr  in  15  data word address; dbus_output  in  48  write data.
REQ-009 dbus_input  out  48  read data; dbus_done  out  1  data access complete, one-cycle pulse.
REQ-010 mem_req  out  1  memory request, held until mem_ack; mem_we  out  1  write strobe qualifier.
REQ-011 mem_addr  out  15; mem_wdata  out  48; mem_rdata  in  48; mem_ack  in  1  memory completion, may arrive in the same cycle as mem_req.
REQ-012 bus_error  out  1  sticky timeout flag; err_clear  in  1  clears bus_error.

Function
REQ-013 FSM states IDLE, ACCESS, RESP; one outstanding memory transaction at any time.
REQ-014 IDLE: a sampled request grants; mem_req/mem_we/mem_addr/mem_wdata registered from the granted port; next state ACCESS.
REQ-015 Both ports pending in IDLE: dbus wins, except when the previous grant was dbus; then ibus wins (alternating).
REQ-016 ACCESS: mem_req held with stable addr/data until mem_ack; on mem_ack capture mem_rdata (reads only), drop mem_req, go RESP.
REQ-017 RESP: assert the granted port's done for exactly one cycle with captured data driven on ibus_input/dbus_input in that same cycle; next state IDLE.
REQ-018 Minimum access latency: request in IDLE at cycle N -> mem_req at N+1 -> done at N+2 with zero-wait ack; 3 cycles between back-to-back grants.
REQ-019 The request still asserted during the RESP cycle is not re-granted; IDLE re-samples on the following cycle, so consecutive core accesses to any address are distinct transactions.
REQ-020 ibus_input/dbus_input hold last captured value outside RESP; a write leaves dbus_input unchanged.
REQ-021 Timeout: 8-bit counter cleared on entering ACCESS, increments each ACCESS cycle without mem_ack; at 255 force RESP with read data 0, drop mem_req, set bus_error.
REQ-022 bus_error cleared by err_clear; a simultaneous timeout wins (flag stays set).
REQ-023 Request withdrawn by core during ACCESS: transaction completes on memory side, RESP still taken, done pulse still issued.
REQ-024 Done pulses only to the granted port; the other port's done stays 0.

Reset
REQ-025 reset low: FSM IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, ibus_done 0, dbus_done 0, ibus_input 0, dbus_input 0, bus_error 0, timeout counter 0, last-grant = ibus.
REQ-026 Reset asserted mid-ACCESS aborts immediately; mem_req drops asynchronously; no done pulse after release.
REQ-027 First grant no earlier than the second rising edge after reset release.

Structure
REQ-028 State encoding, timeout limit (255) and address/data widths (15, 48) defined in mesm6_defines.sv.
REQ-029 Single module, no sub-modules; timeout counter inline.

Verification
REQ-030 Fetch addr 0x0100, mem_ack same cycle as mem_req, rdata 0x0123456789AB -> ibus_done one cycle at N+2, ibus_input = 0x0123456789AB.
REQ-031 dbus_write addr 0x7FFF data 0xFFFFFFFFFFFF, ack after 5 wait cycles -> mem_we=1, mem_wdata stable all 6 cycles, dbus_done one pulse, dbus_input unchanged.
REQ-032 ibus_fetch and dbus_read asserted together, both held -> dbus granted first, then ibus; no double grant of either.
REQ-033 dbus_read held across two accesses (addr 5 then 6), rdata 0xA then 0xB -> two separate transactions, two done pulses, data 0xA then 0xB.
REQ-034 mem_ack never asserted -> done after 255 ACCESS cycles, dbus_input = 0, bus_error = 1; err_clear pulse -> bus_error = 0.
REQ-035 reset low during ACCESS -> mem_req 0 immediately, no done pulse; post-release fetch completes normally.
